// File: rtl/adc_seq_pkg.sv
// Shared types and XADC DRP constants for the ADC sample sequencer.
package adc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DRP_AW  = 7;
    localparam int DRP_DW  = 16;
    localparam int RES_W   = 12;
    localparam int RES_MSB = 15;
    localparam int RES_LSB = 4;

    localparam logic [DRP_AW-1:0] CH_BASE_ADDR_DEF = 7'h10;

    // XADC results are MSB-justified: the 12-bit code sits in [15:4].
    function automatic logic [RES_W-1:0] xadc_result(input logic [DRP_DW-1:0] d);
        return RES_W'(d >> RES_LSB);
    endfunction

endpackage

// File: rtl/adc_sample_sequencer_if.sv
// XADC DRP port bundle; the sequencer is the master, the XADC the slave.
interface adc_sample_sequencer_if;
    import adc_seq_pkg::*;

    logic              drp_den;
    logic              drp_dwe;
    logic [DRP_AW-1:0] drp_daddr;
    logic [DRP_DW-1:0] drp_di;
    logic [DRP_DW-1:0] drp_do;
    logic              drp_drdy;

    modport master (
        output drp_den, drp_dwe, drp_daddr, drp_di,
        input  drp_do, drp_drdy
    );

    modport slave (
        input  drp_den, drp_dwe, drp_daddr, drp_di,
        output drp_do, drp_drdy
    );

endinterface

// File: rtl/adc_sample_sequencer_drp_read_timeout.sv
// WAIT-cycle counter for one DRP read; expired flags the last allowed WAIT cycle.
module drp_read_timeout #(
    parameter int TIMEOUT_CYC = 63
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

    logic [7:0] cnt_q;

    // cnt_q holds the number of WAIT cycles already spent on this read
    assign expired = enable && (cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/adc_sample_sequencer.sv
// Reads NUM_CH XADC channels over DRP per trigger and publishes them as one atomic frame.
// Optional threshold trip flags are built when ADC_SEQ_THRESH_EN is defined.
module adc_sample_sequencer
    import adc_seq_pkg::*;
#(
    parameter int                NUM_CH       = 4,
    parameter logic [DRP_AW-1:0] CH_BASE_ADDR = CH_BASE_ADDR_DEF,
    parameter int                TIMEOUT_CYC  = 63
`ifdef ADC_SEQ_THRESH_EN
    ,
    parameter logic [RES_W-1:0]  TRIP_LEVEL   = 12'hE00
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    trigger,
    input  logic                    err_clear,
    adc_sample_sequencer_if.master  drp,
    output logic [RES_W*NUM_CH-1:0] sample_data,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    overrun,
    output logic                    timeout_err,
    output logic [NUM_CH-1:0]       trip
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    state_e                  state_q, state_nxt;
    logic [IDX_W-1:0]        idx_q, idx_nxt;
    logic [RES_W-1:0]        shadow_q   [NUM_CH];
    logic [RES_W-1:0]        shadow_nxt [NUM_CH];
    logic [RES_W*NUM_CH-1:0] frame_nxt;
    logic                    tmo_set;
    logic                    ovr_set;
    logic                    expired;

    drp_read_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q == ISSUE),
        .enable  (state_q == WAIT),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
        end else begin
            state_q  <= state_nxt;
            idx_q    <= idx_nxt;
            shadow_q <= shadow_nxt;
        end
    end

    // Responses arriving in IDLE, ISSUE or DONE are stale and never captured.
    always_comb begin
        state_nxt  = state_q;
        idx_nxt    = idx_q;
        shadow_nxt = shadow_q;
        tmo_set    = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    idx_nxt   = '0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (drp.drp_drdy || expired) begin
                    if (drp.drp_drdy) shadow_nxt[idx_q] = xadc_result(drp.drp_do);
                    else              tmo_set = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx_q + 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ovr_set = trigger && (state_q != IDLE);

    // Outputs are registered from next-state values so the frame is visible in DONE.
    always_comb begin
        frame_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) frame_nxt[RES_W*i +: RES_W] = shadow_nxt[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drp.drp_den   <= 1'b0;
            drp.drp_daddr <= '0;
            busy          <= 1'b0;
            sample_valid  <= 1'b0;
            sample_data   <= '0;
            overrun       <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            drp.drp_den  <= (state_nxt == ISSUE);
            busy         <= (state_nxt != IDLE);
            sample_valid <= (state_nxt == DONE);
            if (state_nxt == ISSUE) drp.drp_daddr <= CH_BASE_ADDR + DRP_AW'(idx_nxt);
            if (state_nxt == DONE)  sample_data   <= frame_nxt;
            overrun     <= ovr_set || (overrun && !err_clear);
            timeout_err <= tmo_set || (timeout_err && !err_clear);
        end
    end

    assign drp.drp_dwe = 1'b0;
    assign drp.drp_di  = '0;

`ifdef ADC_SEQ_THRESH_EN
    logic [NUM_CH-1:0] trip_set;

    always_comb begin
        trip_set = '0;
        if (state_nxt == DONE) begin
            for (int i = 0; i < NUM_CH; i++) trip_set[i] = (shadow_nxt[i] >= TRIP_LEVEL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trip <= '0;
        else        trip <= trip_set | (trip & ~{NUM_CH{err_clear}});
    end
`else
    assign trip = '0;
`endif

endmodule
